mips_run_ctrl: RTL
==================

// Module: mips_run_ctrl
// PURPOSE
//  Run controller for the pipelined MIPS CPU in simulation/FPGA bring-up: sequences CPU reset,
//  then runs the core until it halts (PC self-loop), times out, or is aborted. Reports cycle and
//  retired-instruction counts plus a termination status. Replaces fixed-delay reset/finish timing
//  with a parametrised, restartable state machine sitting between the top-level bench and mips.
// PARAMETERS
//  RESET_CYCLES  2    cycles cpu_reset held high after start (>=1)
//  MAX_CYCLES    50   RUN-cycle budget before timeout (>=1, < 2**CNT_W)
//  HALT_REPEAT   4    consecutive cycles PC must equal previous-cycle PC to declare halt (>=1)
//  PC_W          32   width of monitored PC
//  CNT_W         32   width of cycle/retire counters
// PORTS
//  clk         in   1      system clock, all logic on posedge
//  reset       in   1      synchronous, active-high
//  start       in   1      1-cycle request; honoured in IDLE and DONE only
//  abort       in   1      force termination while in RUN
//  pc          in   PC_W   F-stage PC of the CPU
//  retire      in   1      one instruction committed at W stage this cycle
//  cpu_reset   out  1      reset to CPU (drives mips.reset)
//  cpu_en      out  1      CPU clock enable; 0 freezes architectural state
//  running     out  1      high in RUN
//  done        out  1      high in DONE
//  status      out  2      00 none, 01 halt, 10 timeout, 11 abort
//  cycle_cnt   out  CNT_W  RUN cycles elapsed, incl. terminating cycle
//  retire_cnt  out  CNT_W  retire pulses counted during RUN
// BEHAVIOUR
//  - All outputs registered. Reset -> state IDLE; cpu_reset=1, cpu_en=1, running=0, done=0,
//    status=00, cycle_cnt=0, retire_cnt=0, halt-repeat counter=0, pc_q valid flag=0.
//  - States: IDLE, RST, RUN, DONE.
//  - IDLE: cpu_reset=1, cpu_en=1. start -> RST; clears counters, status, pc_q valid.
//  - RST: cpu_reset=1 for exactly RESET_CYCLES cycles (counted from the cycle after start), then RUN.
//  - RUN: cpu_reset=0, cpu_en=1, running=1. Each cycle cycle_cnt+=1; retire -> retire_cnt+=1.
//    Both counters saturate at all-ones (no wrap).
//  - Halt detect: pc_q <= pc each RUN cycle, valid from 2nd RUN cycle. If valid && pc==pc_q:
//    same_cnt+=1, else same_cnt=0. Halt when pc==pc_q and same_cnt==HALT_REPEAT-1.
//  - Timeout when the incremented cycle_cnt equals MAX_CYCLES.
//  - Termination -> DONE next cycle; priority abort(11) > halt(01) > timeout(10) when simultaneous.
//    The terminating cycle is counted in cycle_cnt and its retire in retire_cnt.
//  - DONE: cpu_reset=0, cpu_en=0 (state frozen for inspection), done=1, status/counters held.
//    start -> RST (full restart, counters and status cleared). abort ignored.
//  - start in RST/RUN ignored; abort outside RUN ignored; retire/pc ignored outside RUN.
//  - reset at any time (incl. mid-RUN) -> IDLE with reset values next cycle; no partial state kept.
// STRUCTURE
//  - Package mips_tb_pkg: state enum (IDLE/RST/RUN/DONE), status codes ST_NONE/ST_HALT/
//    ST_TIMEOUT/ST_ABORT, shared by bench and checkers.
//  - Sub-module sat_counter #(W) (clr, inc, q): instantiated for cycle_cnt and retire_cnt.
//  - FSM, RST down-counter, pc_q/same_cnt halt detector in the top module.
// TESTING
//  1 Defaults; start at T0 -> cpu_reset high T1..T2, low and running=1 from T3.
//  2 pc += 4 every cycle, no retire -> done after 50 RUN cycles, status=10, cycle_cnt=50.
//  3 pc stuck at 0x3010 from RUN cycle 10, retire on cycles 1..7 -> status=01, cycle_cnt=14,
//    retire_cnt=7, cpu_en=0 in DONE.
//  4 MAX_CYCLES=14 with scenario 3 plus abort on cycle 14 -> status=11 (priority check).
//  5 reset asserted on RUN cycle 5 -> next cycle IDLE, cpu_reset=1, counters 0, status=00.
//  6 start in DONE after scenario 3 -> RST, counters/status cleared, identical rerun result;
//    start pulses during RST/RUN have no effect.

Source files
------------

// File: rtl/mips_tb_pkg.sv
// Shared definitions for the MIPS run controller: FSM state encoding and termination status codes.
package mips_tb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_ABORT   = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS core: sequences CPU reset, runs until halt, timeout
// or abort, and reports cycle/retire counts with a termination status.
//
// Handshake: start and abort are single-cycle level requests sampled on posedge clk; start is
// accepted only in IDLE or DONE, abort only in RUN, and both are silently dropped elsewhere.
module mips_run_ctrl
  import mips_tb_pkg::*;
#(
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 50,
  parameter int HALT_REPEAT  = 4,
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PC_W-1:0]  pc,
  input  logic             retire,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             running,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int HW = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT) : 1;

  state_t            state;
  logic [RW-1:0]     rst_cnt;
  logic [PC_W-1:0]   pc_q;
  logic              pc_vld;
  logic [HW-1:0]     same_cnt;

  logic              in_run;
  logic              cnt_clr;
  logic              pc_same;
  logic              halt_hit;
  logic              tmo_hit;
  logic              term;
  logic [1:0]        term_code;
  logic [CNT_W-1:0]  cycle_next;

  assign in_run  = (state == S_RUN);
  assign cnt_clr = start && ((state == S_IDLE) || (state == S_DONE));

  assign pc_same  = pc_vld && (pc == pc_q);
  assign halt_hit = pc_same && (same_cnt == HW'(HALT_REPEAT - 1));

  // Timeout looks at the value cycle_cnt takes on this edge so the terminating cycle is counted.
  assign cycle_next = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 1'b1;
  assign tmo_hit    = (cycle_next == CNT_W'(MAX_CYCLES));

  assign term      = abort || halt_hit || tmo_hit;
  assign term_code = abort    ? ST_ABORT :
                     halt_hit ? ST_HALT  :
                     tmo_hit  ? ST_TIMEOUT : ST_NONE;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (in_run),
    .q     (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (in_run && retire),
    .q     (retire_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cpu_reset <= 1'b1;
      cpu_en    <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      status    <= ST_NONE;
      rst_cnt   <= '0;
      pc_q      <= '0;
      pc_vld    <= 1'b0;
      same_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RST;
            cpu_reset <= 1'b1;
            cpu_en    <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            status    <= ST_NONE;
            rst_cnt   <= RW'(RESET_CYCLES - 1);
            pc_vld    <= 1'b0;
            same_cnt  <= '0;
          end
        end
        S_RST: begin
          if (rst_cnt == '0) begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
            cpu_en    <= 1'b1;
            running   <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        S_RUN: begin
          pc_q   <= pc;
          pc_vld <= 1'b1;
          if (pc_same && !halt_hit) begin
            same_cnt <= same_cnt + 1'b1;
          end else begin
            same_cnt <= '0;
          end
          if (term) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
            cpu_en  <= 1'b0;
            status  <= term_code;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
